// File: rtl/mem_defs.sv
// Shared memory-access definitions: FSM state encoding and RV32 load/store FUNC3 width codes.
// Used by the data memory and the CPU decoder; no logic, no latency.
package mem_defs;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_ACK  = 2'd2;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

endpackage

// File: rtl/load_store_align.sv
// Byte-lane steering for loads/stores: write merge, load extension, misalignment detect.
// Purely combinational (zero latency); no flow control.
module load_store_align
  import mem_defs::*;
(
  input  logic        is_write,
  input  logic [2:0]  func3,
  input  logic [1:0]  lane,
  input  logic [31:0] store_data,
  input  logic [31:0] mem_word,
  output logic [31:0] merged_word,
  output logic [31:0] load_data,
  output logic        misaligned
);

  logic [3:0]  byte_mask;
  logic [31:0] bit_mask;
  logic [31:0] shifted;
  logic [7:0]  sel_byte;
  logic [15:0] sel_half;

  always_comb begin
    byte_mask  = 4'b0000;
    shifted    = store_data;
    misaligned = 1'b0;
    if (is_write) begin
      case (func3)
        F3_B: begin
          byte_mask = 4'b0001 << lane;
          shifted   = {4{store_data[7:0]}};
        end
        F3_H: begin
          byte_mask  = lane[1] ? 4'b1100 : 4'b0011;
          shifted    = {2{store_data[15:0]}};
          misaligned = lane[0];
        end
        default: begin
          byte_mask  = 4'b1111;
          misaligned = |lane;
        end
      endcase
    end else begin
      case (func3)
        F3_B, F3_BU: misaligned = 1'b0;
        F3_H, F3_HU: misaligned = lane[0];
        default:     misaligned = |lane;
      endcase
    end
    // A suppressed store leaves every lane untouched.
    if (misaligned) byte_mask = 4'b0000;
  end

  assign bit_mask    = {{8{byte_mask[3]}}, {8{byte_mask[2]}}, {8{byte_mask[1]}}, {8{byte_mask[0]}}};
  assign merged_word = (mem_word & ~bit_mask) | (shifted & bit_mask);

  assign sel_byte = mem_word[{lane, 3'b000} +: 8];
  assign sel_half = lane[1] ? mem_word[31:16] : mem_word[15:0];

  always_comb begin
    load_data = mem_word;
    case (func3)
      F3_B:    load_data = {{24{sel_byte[7]}}, sel_byte};
      F3_H:    load_data = {{16{sel_half[15]}}, sel_half};
      F3_BU:   load_data = {24'h0, sel_byte};
      F3_HU:   load_data = {16'h0, sel_half};
      default: load_data = mem_word;
    endcase
    if (misaligned) load_data = 32'h0;
  end

endmodule

// File: rtl/data_memory.sv
// Multi-cycle data memory: IDLE/WAIT/ACK handshake, access executes after LATENCY wait cycles.
// BUSYWAIT stalls the CPU for LATENCY+1 cycles per request and drops in the ACK cycle.
module data_memory
  import mem_defs::*;
#(
  parameter int LATENCY   = 4,
  parameter int ADDR_BITS = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [31:0] mem_address,
  input  logic [31:0] mem_write_data,
  input  logic [2:0]  func3,
  output logic [31:0] read_data,
  output logic        busywait,
  output logic        misaligned
);

  localparam logic [3:0] COUNT_INIT = 4'(LATENCY - 1);

  logic [1:0]           state;
  logic [3:0]           count;
  logic [ADDR_BITS-1:0] req_index;
  logic [1:0]           req_lane;
  logic [31:0]          req_wdata;
  logic [2:0]           req_func3;
  logic                 req_write;

  logic        request;
  logic        execute;
  logic [31:0] mem_word;
  logic [31:0] merged_word;
  logic [31:0] load_data;
  logic        align_misaligned;
  logic        unused_addr_hi;

  logic [31:0] mem [2**ADDR_BITS];

  // Upper address bits are deliberately dropped so addresses wrap around the array.
  assign unused_addr_hi = ^mem_address[31:ADDR_BITS+2];

  assign request  = mem_read ^ mem_write;
  assign execute  = (state == ST_WAIT) && (count == 4'd0);
  assign busywait = !reset && (((state == ST_IDLE) && request) || (state == ST_WAIT));
  assign mem_word = mem[req_index];

  load_store_align u_align (
    .is_write    (req_write),
    .func3       (req_func3),
    .lane        (req_lane),
    .store_data  (req_wdata),
    .mem_word    (mem_word),
    .merged_word (merged_word),
    .load_data   (load_data),
    .misaligned  (align_misaligned)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      count      <= 4'd0;
      read_data  <= 32'h0;
      misaligned <= 1'b0;
      req_index  <= '0;
      req_lane   <= 2'b00;
      req_wdata  <= 32'h0;
      req_func3  <= 3'b000;
      req_write  <= 1'b0;
    end else begin
      misaligned <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (request) begin
            req_index <= mem_address[ADDR_BITS+1:2];
            req_lane  <= mem_address[1:0];
            req_wdata <= mem_write_data;
            req_func3 <= func3;
            req_write <= mem_write;
            count     <= COUNT_INIT;
            state     <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (count == 4'd0) begin
            state      <= ST_ACK;
            misaligned <= align_misaligned;
            if (!req_write) read_data <= load_data;
          end else begin
            count <= count - 4'd1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Array has no reset; an aborted access never reaches the execute edge.
  always_ff @(posedge clk) begin
    if (execute && req_write && !align_misaligned) mem[req_index] <= merged_word;
  end

endmodule

// File: tb/tb_data_memory.sv
// Directed and randomized bench for data_memory against an array-based reference model.
module tb_data_memory;
  localparam int LAT   = 4;
  localparam int ABITS = 8;
  localparam int DEPTH = 2 ** ABITS;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_read, mem_write;
  logic [31:0] mem_address, mem_write_data;
  logic [2:0]  func3;
  logic [31:0] read_data;
  logic        busywait, misaligned;

  int          total = 0;
  int          bad = 0;
  logic [31:0] model_mem [DEPTH];
  logic [31:0] exp_rd;

  data_memory #(.LATENCY(LAT), .ADDR_BITS(ABITS)) dut (
    .clk            (clk),
    .reset          (reset),
    .mem_read       (mem_read),
    .mem_write      (mem_write),
    .mem_address    (mem_address),
    .mem_write_data (mem_write_data),
    .func3          (func3),
    .read_data      (read_data),
    .busywait       (busywait),
    .misaligned     (misaligned)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  function automatic int load_size(input logic [2:0] f);
    if (f == 3'd0 || f == 3'd4) return 1;
    if (f == 3'd1 || f == 3'd5) return 2;
    return 4;
  endfunction

  function automatic int store_size(input logic [2:0] f);
    if (f == 3'd0) return 1;
    if (f == 3'd1) return 2;
    return 4;
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] word, input logic [2:0] f,
                                             input logic [31:0] a);
    longint v;
    int size = load_size(f);
    int off = int'(a % 4);
    v = (longint'(word) >> (8 * off)) % (longint'(1) << (8 * size));
    if ((f == 3'd0 || f == 3'd1) && v >= (longint'(1) << (8 * size - 1)))
      v = v - (longint'(1) << (8 * size));
    return v[31:0];
  endfunction

  function automatic logic [31:0] model_store(input logic [31:0] word, input logic [2:0] f,
                                              input logic [31:0] a, input logic [31:0] d);
    logic [7:0] b [4];
    int off = int'(a % 4);
    for (int k = 0; k < 4; k++) b[k] = 8'((word >> (8 * k)) % 256);
    for (int i = 0; i < store_size(f); i++) b[off + i] = 8'((d >> (8 * i)) % 256);
    return {b[3], b[2], b[1], b[0]};
  endfunction

  // Drives one request, holds it until BUSYWAIT falls, then checks against the model.
  task automatic access(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic [2:0] f, input string tag);
    int          busy = 0;
    int          idx;
    logic [31:0] rd_obs;
    logic        mis_obs, mis_after;
    bit          mis_exp;
    mem_read = r; mem_write = w; mem_address = a; mem_write_data = d; func3 = f;
    #1;
    while (busywait && busy <= 40) begin
      busy++;
      @(negedge clk);
    end
    rd_obs  = read_data;
    mis_obs = misaligned;
    mem_read = 1'b0; mem_write = 1'b0;
    @(negedge clk);
    mis_after = misaligned;

    idx     = int'((a >> 2) % DEPTH);
    mis_exp = w ? (a % store_size(f)) != 0 : (a % load_size(f)) != 0;
    if (r) exp_rd = mis_exp ? 32'h0 : model_load(model_mem[idx], f, a);
    else if (!mis_exp) model_mem[idx] = model_store(model_mem[idx], f, a, d);

    check({tag, "_busy"}, 32'(busy), 32'(LAT + 1));
    check({tag, "_mis"}, {31'h0, mis_obs}, {31'h0, mis_exp});
    check({tag, "_rdata"}, rd_obs, exp_rd);
    check({tag, "_mis_clr"}, {31'h0, mis_after}, 32'h0);
  endtask

  initial begin
    reset = 1'b1; mem_read = 1'b0; mem_write = 1'b0;
    mem_address = 32'h0; mem_write_data = 32'h0; func3 = 3'b010;
    exp_rd = 32'h0;
    @(negedge clk);
    check("rst_busy", {31'h0, busywait}, 32'h0);
    check("rst_rdata", read_data, 32'h0);
    check("rst_mis", {31'h0, misaligned}, 32'h0);
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < DEPTH; i++) access(1'b0, 1'b1, 32'(i * 4), $urandom, 3'b010, "init");

    // Case 1: store then load a full word.
    access(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 3'b010, "c1_sw");
    access(1'b1, 1'b0, 32'h10, 32'h0, 3'b010, "c1_lw");
    check("c1_value", read_data, 32'hDEADBEEF);

    // Case 2: byte store and signed/unsigned byte loads.
    access(1'b0, 1'b1, 32'h20, 32'h0, 3'b010, "c2_clr");
    access(1'b0, 1'b1, 32'h21, 32'h80, 3'b000, "c2_sb");
    access(1'b1, 1'b0, 32'h20, 32'h0, 3'b010, "c2_lw");
    check("c2_word", read_data, 32'h00008000);
    access(1'b1, 1'b0, 32'h21, 32'h0, 3'b000, "c2_lb");
    check("c2_lb_val", read_data, 32'hFFFFFF80);
    access(1'b1, 1'b0, 32'h21, 32'h0, 3'b100, "c2_lbu");
    check("c2_lbu_val", read_data, 32'h00000080);

    // Case 3: misaligned halfword load and store are suppressed.
    access(1'b1, 1'b0, 32'h13, 32'h0, 3'b001, "c3_lh");
    access(1'b0, 1'b1, 32'h13, 32'hFFFF, 3'b001, "c3_sh");
    access(1'b1, 1'b0, 32'h10, 32'h0, 3'b010, "c3_lw");
    check("c3_word", read_data, 32'hDEADBEEF);

    // Case 4: both strobes high is no request.
    mem_read = 1'b1; mem_write = 1'b1; mem_address = 32'h10; func3 = 3'b010;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("c4_busy", {31'h0, busywait}, 32'h0);
      check("c4_rdata", read_data, exp_rd);
      @(negedge clk);
    end
    mem_read = 1'b0; mem_write = 1'b0;
    access(1'b1, 1'b0, 32'h14, 32'h0, 3'b010, "c4_after");

    // Case 5: reset aborts an in-flight store.
    mem_write = 1'b1; mem_address = 32'h40; mem_write_data = 32'h12345678; func3 = 3'b010;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("c5_busy", {31'h0, busywait}, 32'h0);
    check("c5_rdata", read_data, 32'h0);
    check("c5_mis", {31'h0, misaligned}, 32'h0);
    exp_rd = 32'h0;
    mem_write = 1'b0;
    // A load held across reset release is taken as a fresh request.
    mem_read = 1'b1; mem_address = 32'h44;
    @(negedge clk);
    #1;
    check("c5_busy_held", {31'h0, busywait}, 32'h0);
    reset = 1'b0;
    access(1'b1, 1'b0, 32'h44, 32'h0, 3'b010, "c5_held");
    access(1'b1, 1'b0, 32'h40, 32'h0, 3'b010, "c5_lw");

    // Case 6: upper address bits wrap onto the array.
    access(1'b0, 1'b1, 32'h400, 32'hCAFEF00D, 3'b010, "c6_sw");
    access(1'b1, 1'b0, 32'h0, 32'h0, 3'b010, "c6_lw");
    check("c6_value", read_data, 32'hCAFEF00D);

    for (int n = 0; n < 150; n++) begin
      logic r = 1'($urandom_range(0, 1));
      access(r, !r, $urandom, $urandom, 3'($urandom_range(0, 7)), "rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
